// File: rtl/lcd_write_seq_if.sv
// lcd_write_seq_if: host-side write request handshake for lcd_write_seq.
interface lcd_write_seq_if;
   logic       wr_en;
   logic       wr_rs;
   logic [7:0] wr_data;
   logic       busy;
   logic       drop;
   modport master (output wr_en, wr_rs, wr_data, input busy, drop);
   modport slave  (input wr_en, wr_rs, wr_data, output busy, drop);
endinterface

// File: rtl/lcd_write_seq.sv
// lcd_write_seq: sequences byte writes to an HD44780-class LCD as two 4-bit nibble transfers.
// Define LCD_LONG_CMD_EN to stretch the settle wait after clear/home commands to T_LONG.
module lcd_write_seq #(
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 12,
   parameter int T_HOLD  = 2,
   parameter int T_GAP   = 50,
   parameter int T_WAIT  = 2000,
   parameter int T_LONG  = 82000,
   parameter int CNT_W   = 17
) (
   input  logic          clk,
   input  logic          rst,
   lcd_write_seq_if.slave host,
   output logic          lcd_e,
   output logic          lcd_rs,
   output logic          lcd_rw,
   output logic [3:0]    lcd_db
);
   typedef enum logic [3:0] {IDLE, SET_H, PUL_H, HLD_H, GAP, SET_L, PUL_L, HLD_L, WAIT} state_t;
   state_t           state, nxt;
   logic [CNT_W-1:0] cnt, ld;
   logic             prev, edge_det, accept, rs, rs_n, long_cmd;
   logic [7:0]       data, data_n;
`ifdef LCD_LONG_CMD_EN
   assign long_cmd = ~rs & (data[7:2] == 6'd0) & (data[1:0] != 2'd0);
`else
   assign long_cmd = 1'b0;
`endif
   assign lcd_rw = 1'b0;
   always_comb begin
      edge_det = host.wr_en & ~prev;
      accept   = edge_det & (state == IDLE);
      rs_n     = accept ? host.wr_rs : rs;
      data_n   = accept ? host.wr_data : data;
      nxt      = state;
      if (state == IDLE) nxt = accept ? SET_H : IDLE;
      else if (cnt == '0) nxt = (state == WAIT) ? IDLE : state_t'(state + 4'd1);
      case (nxt)
         SET_H, SET_L: ld = CNT_W'(T_SETUP - 1);
         PUL_H, PUL_L: ld = CNT_W'(T_PULSE - 1);
         HLD_H, HLD_L: ld = CNT_W'(T_HOLD - 1);
         GAP:          ld = CNT_W'(T_GAP - 1);
         WAIT:         ld = long_cmd ? CNT_W'(T_LONG - 1) : CNT_W'(T_WAIT - 1);
         default:      ld = '0;
      endcase
   end
   // Outputs are registered from the next state so pins change together with the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         prev      <= 1'b1;
         rs        <= 1'b0;
         data      <= '0;
         host.busy <= 1'b0;
         host.drop <= 1'b0;
         lcd_e     <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_db    <= 4'h0;
      end else begin
         prev      <= host.wr_en;
         state     <= nxt;
         cnt       <= (nxt != state) ? ld : (cnt == '0) ? cnt : cnt - CNT_W'(1);
         rs        <= rs_n;
         data      <= data_n;
         host.busy <= nxt != IDLE;
         host.drop <= edge_det & (state != IDLE);
         lcd_e     <= (nxt == PUL_H) || (nxt == PUL_L);
         lcd_rs    <= (nxt inside {[SET_H:HLD_L]}) & rs_n;
         lcd_db    <= (nxt inside {SET_H, PUL_H, HLD_H}) ? data_n[7:4] :
                      (nxt inside {SET_L, PUL_L, HLD_L}) ? data_n[3:0] : 4'h0;
      end
   end
endmodule

// File: tb/tb_lcd_write_seq.sv
// tb_lcd_write_seq: randomized bench comparing lcd_write_seq pins against a per-cycle waveform model.
module tb_lcd_write_seq;
   localparam int T_SETUP = 1, T_PULSE = 2, T_HOLD = 1, T_GAP = 3, T_WAIT = 5, T_LONG = 20;
`ifdef LCD_LONG_CMD_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif
   typedef struct packed {logic rw; logic e; logic rs; logic [3:0] db; logic busy; logic drop;} obs_t;
   logic       clk = 1'b0, rst = 1'b0;
   logic       lcd_e, lcd_rs, lcd_rw;
   logic [3:0] lcd_db;
   int         vectors = 0, errs = 0;
   obs_t       q[$];
   obs_t       act, exp_o;
   lcd_write_seq_if h();
   lcd_write_seq #(.T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD), .T_GAP(T_GAP),
                   .T_WAIT(T_WAIT), .T_LONG(T_LONG), .CNT_W(17)) dut (
      .clk(clk), .rst(rst), .host(h.slave),
      .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db));
   always #5 clk = ~clk;
   assign act = {lcd_rw, lcd_e, lcd_rs, lcd_db, h.busy, h.drop};
   function automatic obs_t mk(logic e, logic rs, logic [3:0] db, logic busy);
      return {1'b0, e, rs, db, busy, 1'b0};
   endfunction
   // Expected pin values for every cycle after the accepting edge, ending with the first idle cycle.
   function automatic void exp_byte(logic rs, logic [7:0] d);
      int w = (LONG_EN && !rs && d inside {8'h01, 8'h02, 8'h03}) ? T_LONG : T_WAIT;
      repeat (T_SETUP) q.push_back(mk(1'b0, rs, d[7:4], 1'b1));
      repeat (T_PULSE) q.push_back(mk(1'b1, rs, d[7:4], 1'b1));
      repeat (T_HOLD)  q.push_back(mk(1'b0, rs, d[7:4], 1'b1));
      repeat (T_GAP)   q.push_back(mk(1'b0, rs, 4'h0, 1'b1));
      repeat (T_SETUP) q.push_back(mk(1'b0, rs, d[3:0], 1'b1));
      repeat (T_PULSE) q.push_back(mk(1'b1, rs, d[3:0], 1'b1));
      repeat (T_HOLD)  q.push_back(mk(1'b0, rs, d[3:0], 1'b1));
      repeat (w)       q.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1));
      q.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0));
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic arm(logic rs, logic [7:0] d);
      h.wr_en = 1'b0;
      tick();
      h.wr_en   = 1'b1;
      h.wr_rs   = rs;
      h.wr_data = d;
   endtask

   task automatic test_reset();
      h.wr_en = 1'b1; h.wr_rs = 1'b1; h.wr_data = 8'hFF;
      #12;
      vectors++;
      if (act !== mk(1'b0, 1'b0, 4'h0, 1'b0)) begin
         errs++; $display("FAIL reset_state: got %h want %h", act, mk(1'b0, 1'b0, 4'h0, 1'b0));
      end
      @(posedge clk); #3 rst = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();
         vectors++;
         if (act !== mk(1'b0, 1'b0, 4'h0, 1'b0)) begin
            errs++; $display("FAIL reset_release_idle cyc%0d: got %h want idle", k, act);
         end
      end
   endtask

   task automatic test_write();
      for (int n = 0; n < 8; n++) begin
         logic       rs = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         logic [7:0] d  = (n == 0) ? 8'hA5 : 8'($urandom);
         arm(rs, d);
         exp_byte(rs, d);
         repeat ($urandom_range(0, 3)) q.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0));
         while (q.size() > 0) begin
            tick();
            exp_o = q.pop_front();
            vectors++;
            if (act !== exp_o) begin errs++; $display("FAIL write byte%0d=%h: got %h want %h", n, d, act, exp_o); end
         end
      end
   endtask

   task automatic test_drop();
      logic       rs = 1'($urandom_range(0, 1));
      logic [7:0] d  = 8'($urandom);
      int         k  = 0;
      arm(rs, d);
      exp_byte(rs, d);
      q[4].drop = 1'b1;
      while (q.size() > 0) begin
         tick();
         exp_o = q.pop_front();
         vectors++;
         if (act !== exp_o) begin errs++; $display("FAIL drop cyc%0d: got %h want %h", k, act, exp_o); end
         if (k == 0) h.wr_en = 1'b0;
         if (k == 3) begin h.wr_en = 1'b1; h.wr_data = ~d; h.wr_rs = ~rs; end
         k++;
      end
      rs = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      arm(rs, d);
      exp_byte(rs, d);
      while (q.size() > 0) begin
         tick();
         exp_o = q.pop_front();
         vectors++;
         if (act !== exp_o) begin errs++; $display("FAIL drop_next: got %h want %h", act, exp_o); end
      end
   endtask

   task automatic test_long_cmd();
      logic [8:0] cases[6] = '{9'h001, 9'h101, 9'h002, 9'h003, 9'h004, 9'h000};
      cases[5] = 9'($urandom);
      foreach (cases[i]) begin
         arm(cases[i][8], cases[i][7:0]);
         exp_byte(cases[i][8], cases[i][7:0]);
         while (q.size() > 0) begin
            tick();
            exp_o = q.pop_front();
            vectors++;
            if (act !== exp_o) begin errs++; $display("FAIL long_cmd %h: got %h want %h", cases[i], act, exp_o); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d = 8'($urandom) | 8'h11;
      arm(1'b1, d);
      exp_byte(1'b1, d);
      for (int k = 0; k < 9; k++) begin
         tick();
         exp_o = q.pop_front();
         vectors++;
         if (act !== exp_o) begin errs++; $display("FAIL mid_pre cyc%0d: got %h want %h", k, act, exp_o); end
      end
      q.delete();
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (act !== mk(1'b0, 1'b0, 4'h0, 1'b0)) begin errs++; $display("FAIL mid_async: got %h want idle", act); end
      @(posedge clk); #3 rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (act !== mk(1'b0, 1'b0, 4'h0, 1'b0)) begin errs++; $display("FAIL mid_idle cyc%0d: got %h want idle", k, act); end
      end
      d = 8'($urandom);
      arm(1'b0, d | 8'h80);
      exp_byte(1'b0, d | 8'h80);
      while (q.size() > 0) begin
         tick();
         exp_o = q.pop_front();
         vectors++;
         if (act !== exp_o) begin errs++; $display("FAIL mid_fresh: got %h want %h", act, exp_o); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] da = 8'($urandom), db = 8'($urandom);
      logic       ra = 1'($urandom_range(0, 1)), rb = 1'($urandom_range(0, 1));
      int         k  = 0;
      arm(ra, da);
      exp_byte(ra, da);
      exp_byte(rb, db);
      while (q.size() > 0) begin
         tick();
         exp_o = q.pop_front();
         vectors++;
         if (act !== exp_o) begin errs++; $display("FAIL back_to_back cyc%0d: got %h want %h", k, act, exp_o); end
         if (k == 16) begin
            h.wr_en = 1'b1; h.wr_rs = rb; h.wr_data = db;
         end else begin
            h.wr_rs = 1'($urandom_range(0, 1)); h.wr_data = 8'($urandom);
            if (k == 2) h.wr_en = 1'b0;
         end
         k++;
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_drop();
      test_long_cmd();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
